spi_readback_tx: RTL
====================

Name: spi_readback_tx

Overview:
- SPI-side read responder. Sits beside the write-path memory manager on the SPI slave's RX/TX byte interface and watches the same command stream.
- On a read command it snapshots the selected field (key, nonce or position) from the stored ChaCha parameters. It then serializes that field byte-by-byte into the SPI slave's TX path, one byte per completed SPI byte exchange.
- It tracks write commands and their data-byte counts so that write payload bytes are never decoded as commands.

Parameters:
- FILL_BYTE, 8'h00: byte loaded into the TX path at reset and after the final byte of a read.

Ports:
- i_Clk  input  1  system clock
- i_Rst  input  1  reset, asynchronous, active-high
- o_RX_DV  input  1  one-cycle pulse from SPI slave: byte received and exchange complete
- o_RX_Byte  input  8  byte received on MOSI
- i_TX_DV  output  1  one-cycle pulse to SPI slave: register i_TX_Byte for the next exchange
- i_TX_Byte  output  8  byte to serialize on MISO
- io_key_0..io_key_7  input  32 each  stored key words
- io_nonce_0..io_nonce_2  input  32 each  stored nonce words
- io_position  input  32  stored position word
- o_Busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock, i_Clk. i_Rst is asynchronous, active-high.
- Reset values:
  - state = IDLE; o_Busy = 0; i_TX_DV = 0; i_TX_Byte = FILL_BYTE.
  - Byte index and length counters (6-bit) = 0; 256-bit snapshot register = 0.
- Registered outputs: i_TX_DV and i_TX_Byte are registered. i_TX_DV is never high for two consecutive cycles unless two o_RX_DV pulses arrive on consecutive cycles.
- Field byte order is little-endian per word, words in ascending index:
  - key byte 0 = io_key_0[7:0], byte 3 = io_key_0[31:24], byte 31 = io_key_7[31:24];
  - nonce bytes 0..11 follow io_nonce_0..io_nonce_2 the same way;
  - position bytes 0..3 = io_position[7:0]..[31:24].
- Command decoding applies only in IDLE, and only on an o_RX_DV pulse. o_RX_Byte values:
  - 1, 2, 3 (write key, nonce, position): go to SKIP with remaining count 32, 12 or 4 respectively. No TX activity.
  - 4, 5, 6 (read key, nonce, position):
    - capture the selected field into the snapshot, zero-extended to 256 bits;
    - set length to 32, 12 or 4 and index to 0;
    - go to SEND;
    - next cycle: i_TX_DV = 1 and i_TX_Byte = snapshot byte 0.
  - 7 (start) and all other values: stay in IDLE, no TX activity.
- SKIP: each o_RX_DV decrements the remaining count. When the pulse that brings the count to 0 arrives, go to IDLE on that edge. o_RX_Byte is ignored and i_TX_DV stays 0.
- SEND: each o_RX_DV means byte[index] has been shifted out; o_RX_Byte is ignored (dummy byte).
  - If index + 1 < length: index++, and next cycle i_TX_DV = 1 with i_TX_Byte = byte[index + 1].
  - If index + 1 == length: i_TX_DV = 1 with i_TX_Byte = FILL_BYTE, index = 0, state = IDLE.
- Latency: o_RX_DV at cycle N produces i_TX_DV at cycle N+1, in every case that emits a byte.
- Snapshot stability: the snapshot is taken in the command cycle. Changes on io_* inputs during SEND do not affect bytes already captured.
- Back-to-back pulses: o_RX_DV on consecutive cycles is handled, one byte step per pulse, with no dropped pulse.
- Reset mid-operation: any state returns to IDLE immediately. No further i_TX_DV pulses occur. A partial read is abandoned, not resumed.
- Command immediately after a read: the FILL_BYTE pulse and the IDLE entry occur on the same edge. The next o_RX_DV after that is decoded as a command.

Test Plan:
- Reset, then send 0x06 with io_position = 32'hA1B2C3D4 -> i_TX_DV one cycle after the command with byte 0xD4. Three dummy o_RX_DV pulses give 0xC3, 0xB2, 0xA1. A fourth gives FILL_BYTE 0x00 and o_Busy drops.
- Send 0x04 with io_key_k = 32'h03020100 + k*32'h04040404 -> 32 bytes 0x00..0x1F in order, then 0x00 fill. Change io_key_0 to 0xFFFFFFFF mid-read -> bytes still 0x00..0x1F.
- Send 0x02 followed by 12 data bytes including values 0x04 and 0x05 -> no i_TX_DV at all. Then send 0x05 -> nonce readback starts, proving the skip count was exactly 12.
- Send 0x05, then o_RX_DV on 12 consecutive cycles -> 12 i_TX_DV pulses on consecutive cycles with correct nonce bytes, then fill, then IDLE.
- Send 0x04, exchange 5 bytes, assert i_Rst for 1 cycle -> i_TX_DV = 0, i_TX_Byte = 0x00, o_Busy = 0. Then send 0x06 -> position byte 0 emitted.
- Send 0x07, 0x00 and 0xFF in IDLE -> no i_TX_DV and o_Busy stays 0.

Source files
------------

// File: rtl/spi_readback_tx.sv
// Read responder on the SPI slave byte interface: decodes read/write commands,
// snapshots the selected ChaCha field and streams it out one byte per exchange.
module spi_readback_tx #(
   parameter logic [7:0] FILL_BYTE = 8'h00
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        o_RX_DV,
   input  logic [7:0]  o_RX_Byte,
   output logic        i_TX_DV,
   output logic [7:0]  i_TX_Byte,
   input  logic [31:0] io_key_0,
   input  logic [31:0] io_key_1,
   input  logic [31:0] io_key_2,
   input  logic [31:0] io_key_3,
   input  logic [31:0] io_key_4,
   input  logic [31:0] io_key_5,
   input  logic [31:0] io_key_6,
   input  logic [31:0] io_key_7,
   input  logic [31:0] io_nonce_0,
   input  logic [31:0] io_nonce_1,
   input  logic [31:0] io_nonce_2,
   input  logic [31:0] io_position,
   output logic        o_Busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SKIP = 2'd1,
      SEND = 2'd2
   } state_t;

   localparam logic [7:0] CMD_WR_KEY   = 8'd1;
   localparam logic [7:0] CMD_WR_NONCE = 8'd2;
   localparam logic [7:0] CMD_WR_POS   = 8'd3;
   localparam logic [7:0] CMD_RD_KEY   = 8'd4;
   localparam logic [7:0] CMD_RD_NONCE = 8'd5;
   localparam logic [7:0] CMD_RD_POS   = 8'd6;

   state_t        state_q, state_d;
   logic [5:0]    idx_q, idx_d;
   logic [5:0]    len_q, len_d;
   logic [255:0]  snap_q, snap_d;
   logic          tx_dv_q, tx_dv_d;
   logic [7:0]    tx_byte_q, tx_byte_d;

   logic [255:0]  key_field, nonce_field, pos_field;
   logic [255:0]  rd_field;
   logic [5:0]    rd_len;
   logic          rd_hit;
   logic [5:0]    wr_len;
   logic          wr_hit;
   logic [5:0]    idx_inc;
   logic [7:0]    snap_bytes [32];

   // Word 0 sits in the low bits so byte N of the field is simply bits [8N+7:8N].
   assign key_field   = {io_key_7, io_key_6, io_key_5, io_key_4,
                         io_key_3, io_key_2, io_key_1, io_key_0};
   assign nonce_field = {160'd0, io_nonce_2, io_nonce_1, io_nonce_0};
   assign pos_field   = {224'd0, io_position};

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_snap_bytes
         assign snap_bytes[gi] = snap_q[gi*8 +: 8];
      end
   endgenerate

   assign idx_inc = idx_q + 6'd1;

   always_comb begin
      rd_hit   = 1'b1;
      rd_field = '0;
      rd_len   = '0;
      case (o_RX_Byte)
         CMD_RD_KEY: begin
            rd_field = key_field;
            rd_len   = 6'd32;
         end
         CMD_RD_NONCE: begin
            rd_field = nonce_field;
            rd_len   = 6'd12;
         end
         CMD_RD_POS: begin
            rd_field = pos_field;
            rd_len   = 6'd4;
         end
         default: rd_hit = 1'b0;
      endcase
   end

   always_comb begin
      wr_hit = 1'b1;
      wr_len = '0;
      case (o_RX_Byte)
         CMD_WR_KEY:   wr_len = 6'd32;
         CMD_WR_NONCE: wr_len = 6'd12;
         CMD_WR_POS:   wr_len = 6'd4;
         default:      wr_hit = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      snap_d    = snap_q;
      tx_dv_d   = 1'b0;
      tx_byte_d = tx_byte_q;
      case (state_q)
         IDLE: begin
            if (o_RX_DV) begin
               if (rd_hit) begin
                  snap_d    = rd_field;
                  len_d     = rd_len;
                  idx_d     = '0;
                  tx_dv_d   = 1'b1;
                  tx_byte_d = rd_field[7:0];
                  state_d   = SEND;
               end else if (wr_hit) begin
                  len_d   = wr_len;
                  state_d = SKIP;
               end
            end
         end
         SKIP: begin
            // len_q doubles as the remaining payload count while skipping.
            if (o_RX_DV) begin
               len_d = len_q - 6'd1;
               if (len_q == 6'd1) begin
                  state_d = IDLE;
               end
            end
         end
         SEND: begin
            if (o_RX_DV) begin
               tx_dv_d = 1'b1;
               if (idx_inc < len_q) begin
                  idx_d     = idx_inc;
                  tx_byte_d = snap_bytes[idx_inc[4:0]];
               end else begin
                  idx_d     = '0;
                  tx_byte_d = FILL_BYTE;
                  state_d   = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         len_q     <= '0;
         snap_q    <= '0;
         tx_dv_q   <= 1'b0;
         tx_byte_q <= FILL_BYTE;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         snap_q    <= snap_d;
         tx_dv_q   <= tx_dv_d;
         tx_byte_q <= tx_byte_d;
      end
   end

   assign i_TX_DV   = tx_dv_q;
   assign i_TX_Byte = tx_byte_q;
   assign o_Busy    = (state_q != IDLE);

endmodule
